// File: rtl/condicionador_botoes.sv
// rtl/condicionador_botoes.sv - push-button synchroniser, debouncer and press-pulse generator
// Each channel: 2-FF sync, 4-state debounce FSM, single-cycle pulse on accepted press; counts moves.
module condicionador_botoes #(
  parameter int N_BOTOES        = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                clear_count,
  input  logic [N_BOTOES-1:0] botoes_raw,
  output logic [N_BOTOES-1:0] pulsos,
  output logic [N_BOTOES-1:0] estado,
  output logic                qualquer,
  output logic [7:0]          jogadas
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    SOLTO,
    CONFIRMA_PRESS,
    PRESSIONADO,
    CONFIRMA_SOLTA
  } estado_t;

  logic [N_BOTOES-1:0] p;
  logic [N_BOTOES-1:0] s1_q, s_q;
  estado_t             st_q  [N_BOTOES];
  estado_t             st_d  [N_BOTOES];
  logic [CW-1:0]       cnt_q [N_BOTOES];
  logic [CW-1:0]       cnt_d [N_BOTOES];
  logic [N_BOTOES-1:0] pulsos_q, pulsos_d;
  logic [N_BOTOES-1:0] estado_q, estado_d;
  logic                qualquer_q, qualquer_d;
  logic [7:0]          jogadas_q, jogadas_d;

  // After this XOR a 1 always means "pressed", whatever the board wiring.
  assign p = botoes_raw ^ {N_BOTOES{ACTIVE_LOW}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q       <= '0;
      s_q        <= '0;
      pulsos_q   <= '0;
      estado_q   <= '0;
      qualquer_q <= 1'b0;
      jogadas_q  <= 8'd0;
      for (int i = 0; i < N_BOTOES; i++) begin
        st_q[i]  <= SOLTO;
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q       <= p;
      s_q        <= s1_q;
      pulsos_q   <= pulsos_d;
      estado_q   <= estado_d;
      qualquer_q <= qualquer_d;
      jogadas_q  <= jogadas_d;
      for (int i = 0; i < N_BOTOES; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_BOTOES; i++) begin
      st_d[i]     = st_q[i];
      cnt_d[i]    = cnt_q[i];
      pulsos_d[i] = 1'b0;
      case (st_q[i])
        SOLTO: begin
          if (s_q[i]) begin
            st_d[i]  = CONFIRMA_PRESS;
            cnt_d[i] = '0;
          end
        end
        CONFIRMA_PRESS: begin
          if (!s_q[i]) begin
            st_d[i] = SOLTO;
          end else if (cnt_q[i] == CNT_MAX) begin
            st_d[i]     = PRESSIONADO;
            // enable only matters on the accepting cycle; a muted press is gone for good
            pulsos_d[i] = enable;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        PRESSIONADO: begin
          if (!s_q[i]) begin
            st_d[i]  = CONFIRMA_SOLTA;
            cnt_d[i] = '0;
          end
        end
        CONFIRMA_SOLTA: begin
          if (s_q[i]) begin
            st_d[i] = PRESSIONADO;
          end else if (cnt_q[i] == CNT_MAX) begin
            st_d[i] = SOLTO;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        default: st_d[i] = SOLTO;
      endcase
      estado_d[i] = (st_d[i] == PRESSIONADO) || (st_d[i] == CONFIRMA_SOLTA);
    end

    qualquer_d = |pulsos_d;
    jogadas_d  = jogadas_q;
    if (clear_count) begin
      jogadas_d = 8'd0;
    end else if (qualquer_d && (jogadas_q != 8'hFF)) begin
      jogadas_d = jogadas_q + 8'd1;
    end
  end

  assign pulsos   = pulsos_q;
  assign estado   = estado_q;
  assign qualquer = qualquer_q;
  assign jogadas  = jogadas_q;

endmodule

// File: tb/tb_condicionador_botoes.sv
// tb/tb_condicionador_botoes.sv - directed bench for condicionador_botoes
// Expected pulses are queued at stimulus time with their due cycle and checked every cycle.
module tb_condicionador_botoes;

  localparam int DEB = 4;
  localparam int LAT = DEB + 3;

  typedef struct {
    int         cyc;
    logic [7:0] val;
    logic [7:0] jog;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       clear_count;
  logic [7:0] botoes_raw;
  logic [7:0] pulsos;
  logic [7:0] estado;
  logic       qualquer;
  logic [7:0] jogadas;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  logic [7:0] jog_model = 8'd0;
  exp_t       sb[$];

  always #5 clk = ~clk;

  condicionador_botoes #(
    .N_BOTOES       (8),
    .DEBOUNCE_CYCLES(DEB),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .clear_count(clear_count),
    .botoes_raw (botoes_raw),
    .pulsos     (pulsos),
    .estado     (estado),
    .qualquer   (qualquer),
    .jogadas    (jogadas)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Queue a pulse due LAT cycles after the raw change just driven.
  task automatic expect_pulse(input logic [7:0] v, input bit clr);
    exp_t e;
    if (clr) jog_model = 8'd0;
    else if (jog_model != 8'hFF) jog_model = jog_model + 8'd1;
    e.cyc = cyc + LAT;
    e.val = v;
    e.jog = jog_model;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      check("pulsos", pulsos, e.val);
      check("qualquer", {7'd0, qualquer}, 8'd1);
      check("jogadas", jogadas, e.jog);
    end else begin
      check("idle_pulsos", pulsos, 8'd0);
      check("idle_qualquer", {7'd0, qualquer}, 8'd0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst         = 1'b1;
    enable      = 1'b1;
    clear_count = 1'b0;
    botoes_raw  = 8'hFF;

    tick();
    check("rst_pulsos", pulsos, 8'd0);
    check("rst_estado", estado, 8'd0);
    check("rst_jogadas", jogadas, 8'd0);
    rst = 1'b0;
    idle(3);

    // clean press on channel 0
    botoes_raw[0] = 1'b0;
    expect_pulse(8'h01, 1'b0);
    idle(LAT - 1);
    check("clean_estado_pre", estado, 8'h00);
    tick();
    check("clean_estado", estado, 8'h01);
    tick();
    check("clean_jogadas", jogadas, 8'd1);
    botoes_raw[0] = 1'b1;
    idle(LAT - 1);
    check("clean_rel_hold", estado, 8'h01);
    tick();
    check("clean_rel", estado, 8'h00);
    idle(2);

    // bouncing press and bouncing release on channel 3
    for (int r = 0; r < 5; r++) begin
      botoes_raw[3] = 1'b0; idle(2);
      botoes_raw[3] = 1'b1; idle(2);
    end
    botoes_raw[3] = 1'b0;
    expect_pulse(8'h08, 1'b0);
    idle(LAT);
    check("bounce_estado", estado, 8'h08);
    for (int r = 0; r < 5; r++) begin
      botoes_raw[3] = 1'b1; idle(2);
      botoes_raw[3] = 1'b0; idle(2);
    end
    check("bounce_rel_hold", estado, 8'h08);
    botoes_raw[3] = 1'b1;
    idle(LAT + 1);
    check("bounce_rel", estado, 8'h00);

    // simultaneous press on channels 1 and 6
    botoes_raw = 8'hBD;
    expect_pulse(8'h42, 1'b0);
    idle(LAT);
    check("simul_estado", estado, 8'h42);
    botoes_raw = 8'hFF;
    idle(LAT + 2);

    // press accepted while muted is lost, even across the enable rise
    enable     = 1'b0;
    botoes_raw = 8'hFB;
    idle(LAT + 2);
    enable = 1'b1;
    idle(3);
    check("gate_estado", estado, 8'h04);
    botoes_raw = 8'hFF;
    idle(LAT + 1);
    check("gate_rel", estado, 8'h00);
    botoes_raw = 8'hFB;
    expect_pulse(8'h04, 1'b0);
    idle(LAT);
    botoes_raw = 8'hFF;
    idle(LAT + 1);

    // saturation
    for (int n = 0; n < 260; n++) begin
      botoes_raw = 8'hDF;
      expect_pulse(8'h20, 1'b0);
      idle(LAT);
      botoes_raw = 8'hFF;
      idle(LAT + 1);
    end
    check("sat_jogadas", jogadas, 8'hFF);

    // clear in the pulse cycle wins over the increment
    botoes_raw = 8'h7F;
    expect_pulse(8'h80, 1'b1);
    idle(LAT - 1);
    clear_count = 1'b1;
    tick();
    clear_count = 1'b0;
    tick();
    check("clear_hold", jogadas, 8'd0);
    botoes_raw = 8'hFF;
    idle(LAT + 1);
    botoes_raw = 8'h7F;
    expect_pulse(8'h80, 1'b0);
    idle(LAT);
    botoes_raw = 8'hFF;
    idle(LAT + 1);

    // reset in the middle of a press, button held through reset release
    botoes_raw = 8'hEF;
    idle(4);
    rst = 1'b1;
    #1;
    check("mid_rst_pulsos", pulsos, 8'd0);
    check("mid_rst_estado", estado, 8'd0);
    check("mid_rst_qualquer", {7'd0, qualquer}, 8'd0);
    check("mid_rst_jogadas", jogadas, 8'd0);
    jog_model = 8'd0;
    tick();
    tick();
    rst = 1'b0;
    expect_pulse(8'h10, 1'b0);
    idle(LAT);
    check("post_rst_estado", estado, 8'h10);
    botoes_raw = 8'hFF;
    idle(LAT + 1);

    check("sb_empty", 8'(sb.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/condicionador_botoes.md
# condicionador_botoes

Conditions the eight raw push-button inputs of the puzzle board into clean, single-cycle toggle pulses for the LED-matrix controller's button input, which toggles its LED group on every cycle a bit is high. Each channel is synchronised, debounced by a per-channel state machine and edge-detected, so one physical press produces exactly one pulse. The block also counts accepted moves for the level/score logic and can mute pulses while the control unit is switching levels.

## Interface
- N_BOTOES, 8: number of button channels.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required to accept a level change (1 ms at 50 MHz). Must be at least 2.
- ACTIVE_LOW, 1: 1 means a raw input of 0 is a press; 0 means a raw input of 1 is a press.
- clk, input, 1: system clock.
- rst, input, 1: reset, asynchronous, active-high.
- enable, input, 1: 1 lets press pulses out; 0 suppresses them while debouncing continues.
- clear_count, input, 1: synchronous clear of jogadas.
- botoes_raw, input, N_BOTOES: asynchronous physical button pins.
- pulsos, output, N_BOTOES: one-cycle pulse per accepted press; feeds the matrix button input.
- estado, output, N_BOTOES: debounced level, 1 means pressed.
- qualquer, output, 1: OR of pulsos, registered in the same cycle as pulsos.
- jogadas, output, 8: saturating count of cycles in which at least one pulse was issued.

## Operation
- Polarity: `p = botoes_raw ^ {N{ACTIVE_LOW}}`, so p = 1 always means pressed.
- Synchroniser: two flip-flops per channel, p → s1 → s. Both reset to 0.
- Counter: per-channel `cnt`, width `$clog2(DEBOUNCE_CYCLES)`.
- Per-channel state machine. States are SOLTO, CONFIRMA_PRESS, PRESSIONADO and CONFIRMA_SOLTA; reset state is SOLTO.
  - SOLTO: if s = 1, go to CONFIRMA_PRESS and set cnt = 0.
  - CONFIRMA_PRESS: if s = 0, go back to SOLTO (a glitch, no pulse).
    - Else if cnt == DEBOUNCE_CYCLES-1, go to PRESSIONADO and set that channel's pulso to 1 when enable = 1.
    - Else increment cnt.
  - PRESSIONADO: if s = 0, go to CONFIRMA_SOLTA and set cnt = 0.
  - CONFIRMA_SOLTA: if s = 1, go back to PRESSIONADO.
    - Else if cnt == DEBOUNCE_CYCLES-1, go to SOLTO. No pulse on release.
    - Else increment cnt.
- estado[i] = 1 in PRESSIONADO and CONFIRMA_SOLTA, 0 otherwise. It is registered alongside the state.
- pulsos is registered and defaults to 0 every cycle, so a pulse is never longer than one cycle.
- enable is sampled on the cycle of the CONFIRMA_PRESS → PRESSIONADO transition only:
  - A press accepted while enable = 0 is lost.
  - It is not replayed when enable later rises.
  - A button held across an enable rise produces no pulse.
- Channels are fully independent. Simultaneous accepted presses assert several pulsos bits in the same cycle.
- jogadas:
  - Increments by 1 on a cycle where the next-state qualquer = 1, even if several bits are set.
  - Saturates at 255.
  - clear_count = 1 forces it to 0 and takes priority over an increment in the same cycle.
- Reset (asynchronous, at any point, including mid-debounce): all states go to SOLTO; cnt, s1, s, pulsos, estado, qualquer and jogadas all go to 0.
  - A button held while reset is released is accepted as a fresh press after the full latency, if enable = 1.

## Timing
- Press latency: raw press first sampled at edge k → pulsos high for the cycle after edge k+2+DEBOUNCE_CYCLES.
  - Breakdown: edge k captures s1, edge k+1 captures s, edge k+2 enters CONFIRMA_PRESS, edge k+2+DEBOUNCE_CYCLES accepts.
- estado rises on the same edge as pulsos.
- Release latency: estado falls at edge k+2+DEBOUNCE_CYCLES after the raw release is first sampled at edge k.
- qualquer is coincident with pulsos. jogadas updates on the same edge that pulsos rises.
- Pulse width: exactly 1 cycle.
- Minimum press-to-press spacing is 2·DEBOUNCE_CYCLES+4 cycles of clean input.
- Bounce shorter than DEBOUNCE_CYCLES cycles in either direction produces no extra pulse.

## Test plan
Run all scenarios with DEBOUNCE_CYCLES=4 and ACTIVE_LOW=1.
- Clean press: botoes_raw[0] goes 1→0 before edge 0 and is held.
  - Expected: pulsos = 8'h01 only between edges 6 and 7; estado[0] = 1 from edge 6; jogadas = 1.
- Bounce: raw[3] alternates 0/1 every 2 cycles for 20 cycles, then holds 0.
  - Expected: exactly one pulse on pulsos[3], 6 cycles after the final stable 0 is sampled; no pulse on release bounce.
- Simultaneous press: raw[1] and raw[6] fall on the same cycle.
  - Expected: pulsos = 8'h42 for one cycle; jogadas increments by 1.
- Enable gating: hold raw[2] low with enable = 0 until acceptance, then raise enable.
  - Expected: no pulse and estado[2] = 1.
  - Then release and press again with enable = 1: one pulse.
- Saturation and clear: 260 accepted presses → jogadas = 255.
  - clear_count asserted in a pulse cycle → jogadas = 0 on the next cycle.
- Reset mid-debounce: assert rst at edge 4 of a press.
  - Expected: all outputs 0 immediately.
  - With the button still held after rst is released, the pulse arrives 6 cycles after the first post-reset sample.
